// File: rtl/cam_capture.sv
// -----------------------------------------------------------------------------
// cam_capture
//
// Camera capture front end for the OV7670 path. Assembles the 8-bit camera
// byte stream into 12-bit RGB444 pixels (from RGB444, RGB565 or grayscale Y
// input) and writes them sequentially into the frame-buffer DP RAM. Capture is
// locked to CAM_vsync, bounded to IMG_W pixels per line and IMG_H lines per
// frame, and flags frame completion and malformed lines.
//
// Ports:
//   CAM_pclk        in   1   pixel clock, all logic on the rising edge
//   rst             in   1   synchronous active-high reset
//   CAM_px_data     in   8   camera data byte
//   CAM_vsync       in   1   high = vertical blanking
//   CAM_href        in   1   high = valid byte on CAM_px_data
//   mode            in   2   0 RGB444, 1 RGB565, 2 gray Y, 3 treated as 0
//   DP_RAM_regW     out  1   write strobe, one cycle per committed pixel
//   DP_RAM_addr_in  out  AW  write address (holds while DP_RAM_regW = 0)
//   DP_RAM_data_in  out  DW  write data {R[3:0],G[3:0],B[3:0]}
//   frame_done      out  1   one-cycle pulse at the end of a captured frame
//   line_err        out  1   one-cycle pulse at the end of a malformed line
//   busy            out  1   high while a frame is being captured
// -----------------------------------------------------------------------------
module cam_capture #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic          CAM_pclk,
    input  logic          rst,
    input  logic [7:0]    CAM_px_data,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [1:0]    mode,
    output logic          DP_RAM_regW,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          frame_done,
    output logic          line_err,
    output logic          busy
);

    // col must be able to hold IMG_W itself (saturation value); row likewise.
    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] COL_END = CW'(IMG_W);
    localparam logic [RW-1:0] ROW_END = RW'(IMG_H);

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_BLANK  = 2'd1,
        S_ACTIVE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_RGB444 = 2'd0,
        MODE_RGB565 = 2'd1,
        MODE_GRAY   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    state_e          state;
    state_e          state_nxt;
    mode_e           mode_q;
    logic [AW-1:0]   wp;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            col_ovf;   // more than IMG_W pixels completed on this line
    logic            phase;     // first byte of a 2-byte pixel is held in b0
    logic [7:0]      b0;
    logic            href_q;    // href seen high during capture last cycle

    logic            frame_start;
    logic            frame_end;
    logic            byte_en;
    logic            line_end;
    logic            two_byte;
    logic            pix_done;
    logic [DW-1:0]   pix;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge CAM_pclk) begin
        if (rst) begin
            state <= S_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state. S_SYNC waits for a vsync high so that a frame already
    // in progress at reset is never partially captured.
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_SYNC:   if (CAM_vsync)  state_nxt = S_BLANK;
            S_BLANK:  if (!CAM_vsync) state_nxt = S_ACTIVE;
            S_ACTIVE: if (CAM_vsync)  state_nxt = S_BLANK;
            default:                  state_nxt = S_SYNC;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs and per-cycle decodes. vsync wins over href, so no byte is
    // accepted in the cycle that ends the frame; a line end in that same cycle
    // is still processed so its line_err coincides with frame_done.
    // -------------------------------------------------------------------------
    always_comb begin
        busy        = (state == S_ACTIVE);
        frame_start = (state == S_BLANK) && !CAM_vsync;
        frame_end   = (state == S_ACTIVE) && CAM_vsync;
        byte_en     = (state == S_ACTIVE) && CAM_href && !CAM_vsync;
        line_end    = (state == S_ACTIVE) && href_q && !CAM_href;
    end

    // -------------------------------------------------------------------------
    // Pixel formatting. The current byte is always the last one of the pixel.
    // RGB565 keeps the top 4 bits of each component.
    // -------------------------------------------------------------------------
    assign two_byte = (mode_q != MODE_GRAY);
    assign pix_done = byte_en && (!two_byte || phase);

    always_comb begin
        case (mode_q)
            MODE_RGB565: pix = {b0[7:4], b0[2:0], CAM_px_data[7], CAM_px_data[4:1]};
            MODE_GRAY:   pix = {3{CAM_px_data[7:4]}};
            default:     pix = {b0[3:0], CAM_px_data};
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: byte assembly, bounded pixel commit, line/frame bookkeeping.
    // -------------------------------------------------------------------------
    always_ff @(posedge CAM_pclk) begin
        if (rst) begin
            mode_q         <= MODE_RGB444;
            wp             <= '0;
            col            <= '0;
            row            <= '0;
            col_ovf        <= 1'b0;
            phase          <= 1'b0;
            b0             <= '0;
            href_q         <= 1'b0;
            DP_RAM_regW    <= 1'b0;
            DP_RAM_addr_in <= '0;
            DP_RAM_data_in <= '0;
            frame_done     <= 1'b0;
            line_err       <= 1'b0;
        end else begin
            DP_RAM_regW <= 1'b0;
            line_err    <= 1'b0;
            frame_done  <= frame_end;
            href_q      <= busy && CAM_href;

            if (frame_start) begin
                mode_q  <= mode_e'(mode);
                wp      <= '0;
                col     <= '0;
                row     <= '0;
                col_ovf <= 1'b0;
                phase   <= 1'b0;
            end else if (line_end) begin
                // Any pending half pixel is simply dropped with phase.
                line_err <= (col != COL_END) || col_ovf || phase;
                col      <= '0;
                col_ovf  <= 1'b0;
                phase    <= 1'b0;
                if (row != ROW_END) begin
                    row <= row + RW'(1);
                end
            end else if (byte_en && two_byte && !phase) begin
                b0    <= CAM_px_data;
                phase <= 1'b1;
            end else if (pix_done) begin
                phase <= 1'b0;
                if (col != COL_END) begin
                    col <= col + CW'(1);
                    // Committed pixels are bounded to IMG_W*IMG_H, so wp
                    // cannot wrap within a frame.
                    if (row != ROW_END) begin
                        DP_RAM_regW    <= 1'b1;
                        DP_RAM_addr_in <= wp;
                        DP_RAM_data_in <= pix;
                        wp             <= wp + AW'(1);
                    end
                end else begin
                    col_ovf <= 1'b1;
                end
            end
        end
    end

endmodule
